instruction_fetch: RTL and testbench

Front stage of the tinycpu pipeline. Holds the program counter, reads instruction words from the word-addressed instruction memory through an enable/ack port, and offers each word to the instruction decoder over the DOR/ack four-phase handshake. Accepts a redirect (branch/jump target) from later stages and discards any fetch made obsolete by it.

---
 rtl/instruction_fetch_pkg.sv | 19 +
 rtl/ifetch_prefetch_buf.sv | 83 ++++++++
 rtl/instruction_fetch.sv | 214 +++++++++++++++++++++
 tb/tb_instruction_fetch.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// ----------------------------------------------------------------------------
// instruction_fetch_pkg
// Shared definitions for the tinycpu fetch stage: fetch FSM state encoding,
// instruction word width and default instruction-memory address width.
// Optional feature macro used by the fetch stage: IFETCH_PREFETCH_EN.
// ----------------------------------------------------------------------------
package instruction_fetch_pkg;

   localparam int unsigned INSTR_W       = 32;
   localparam int unsigned IF_ADDR_W_DEF = 10;

   typedef enum logic [1:0] {
      FETCH_REQ    = 2'd0,
      FETCH_WAIT   = 2'd1,
      OFFER        = 2'd2,
      WAIT_RELEASE = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/ifetch_prefetch_buf.sv
// ----------------------------------------------------------------------------
// ifetch_prefetch_buf
// One-entry prefetch buffer (instruction word + its word address) for the
// fetch stage. Used only when IFETCH_PREFETCH_EN is defined.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   i_issue, i_addr       prefetch request launched to memory at i_addr
//   i_ack, i_word         memory completion and returned word
//   i_flush               redirect: empty buffer, poison any in-flight access
//   i_take                buffer contents consumed by the fetch stage
//   i_handoff             in-flight access taken over by the demand fetch
//   o_valid, o_word       buffer holds o_word for address o_addr
//   o_addr                address of buffered / in-flight prefetch
//   o_busy, o_discard     prefetch in flight; its result will be dropped
// ----------------------------------------------------------------------------
module ifetch_prefetch_buf
   import instruction_fetch_pkg::*;
#(
   parameter int unsigned ADDR_W = IF_ADDR_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_issue,
   input  logic [ADDR_W-1:0]  i_addr,
   input  logic               i_ack,
   input  logic [INSTR_W-1:0] i_word,
   input  logic               i_flush,
   input  logic               i_take,
   input  logic               i_handoff,
   output logic               o_valid,
   output logic [INSTR_W-1:0] o_word,
   output logic [ADDR_W-1:0]  o_addr,
   output logic               o_busy,
   output logic               o_discard
);

   logic               r_valid;
   logic               r_busy;
   logic               r_discard;
   logic [INSTR_W-1:0] r_word;
   logic [ADDR_W-1:0]  r_addr;
   logic               w_fill;

   // a completing access is kept only if no redirect hit it, before or now
   assign w_fill = r_busy & i_ack & ~r_discard & ~i_flush;

   // in-flight tracking and buffer storage
   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid   <= 1'b0;
         r_busy    <= 1'b0;
         r_discard <= 1'b0;
         r_word    <= '0;
         r_addr    <= '0;
      end else begin
         if (i_issue) begin
            r_busy    <= 1'b1;
            r_discard <= 1'b0;
            r_addr    <= i_addr;
         end else if (r_busy && (i_ack || i_handoff)) begin
            r_busy    <= 1'b0;
            r_discard <= 1'b0;
         end else if (r_busy && i_flush) begin
            r_discard <= 1'b1;
         end

         // take has priority so a word forwarded straight from memory is not kept
         if (i_flush || i_take) begin
            r_valid <= 1'b0;
         end else if (w_fill) begin
            r_valid <= 1'b1;
            r_word  <= i_word;
         end
      end
   end

   assign o_valid   = r_valid;
   assign o_word    = r_word;
   assign o_addr    = r_addr;
   assign o_busy    = r_busy;
   assign o_discard = r_discard;

endmodule

// File: rtl/instruction_fetch.sv
// ----------------------------------------------------------------------------
// instruction_fetch
// Front stage of the tinycpu pipeline. Holds the PC, fetches instruction
// words over an enable/ack memory port and offers them to the decoder over a
// DOR/ack four-phase handshake. Redirects from later stages are held pending
// and applied at the next fetch; fetches made obsolete by them are dropped.
// Optional feature: IFETCH_PREFETCH_EN adds a one-word prefetch of pc+1 while
// the decoder handshake is in progress.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   mem_addr, mem_en               fetch word address and request
//   mem_do, mem_ack                returned word and one-cycle completion
//   DOR, data_out, pc_out          word offered to decoder and its address
//   ack_from_next                  decoder acknowledge (level)
//   redirect_valid, redirect_pc    one-cycle redirect pulse and target
// ----------------------------------------------------------------------------
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter int unsigned        ADDR_W   = IF_ADDR_W_DEF,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic               clk,
   input  logic               reset,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic               mem_en,
   input  logic [INSTR_W-1:0] mem_do,
   input  logic               mem_ack,
   output logic               DOR,
   output logic [INSTR_W-1:0] data_out,
   output logic [ADDR_W-1:0]  pc_out,
   input  logic               ack_from_next,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc
);

   fetch_state_t       r_state, w_state_nxt;
   logic [ADDR_W-1:0]  r_pc, w_pc_nxt;
   logic [ADDR_W-1:0]  r_mem_addr, w_mem_addr_nxt;
   logic               r_mem_en, w_mem_en_nxt;
   logic               r_dor, w_dor_nxt;
   logic [INSTR_W-1:0] r_data_out, w_data_nxt;
   logic [ADDR_W-1:0]  r_pc_out, w_pc_out_nxt;
   logic               r_pend, w_pend_nxt;
   logic [ADDR_W-1:0]  r_redir_pc, w_redir_pc_nxt;
   logic [ADDR_W-1:0]  w_fetch_addr;

   assign w_fetch_addr = r_pend ? r_redir_pc : r_pc;

`ifdef IFETCH_PREFETCH_EN
   logic               w_pf_issue;
   logic               w_pf_take;
   logic               w_pf_handoff;
   logic               w_pf_kept;
   logic [ADDR_W-1:0]  w_pf_addr;
   logic               w_buf_valid;
   logic [INSTR_W-1:0] w_buf_word;
   logic [ADDR_W-1:0]  w_buf_addr;
   logic               w_pf_busy;
   logic               w_pf_discard;

   assign w_pf_addr = r_pc_out + ADDR_W'(1);
   // in-flight prefetch completing this cycle with a word worth keeping
   assign w_pf_kept = w_pf_busy & mem_ack & ~w_pf_discard & ~redirect_valid;

   ifetch_prefetch_buf #(
      .ADDR_W (ADDR_W)
   ) u_pf_buf (
      .clk       (clk),
      .reset     (reset),
      .i_issue   (w_pf_issue),
      .i_addr    (w_pf_addr),
      .i_ack     (mem_ack),
      .i_word    (mem_do),
      .i_flush   (redirect_valid),
      .i_take    (w_pf_take),
      .i_handoff (w_pf_handoff),
      .o_valid   (w_buf_valid),
      .o_word    (w_buf_word),
      .o_addr    (w_buf_addr),
      .o_busy    (w_pf_busy),
      .o_discard (w_pf_discard)
   );
`endif

   // state and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= FETCH_REQ;
         r_pc       <= RESET_PC;
         r_mem_addr <= '0;
         r_mem_en   <= 1'b0;
         r_dor      <= 1'b0;
         r_data_out <= '0;
         r_pc_out   <= '0;
         r_pend     <= 1'b0;
         r_redir_pc <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_mem_addr <= w_mem_addr_nxt;
         r_mem_en   <= w_mem_en_nxt;
         r_dor      <= w_dor_nxt;
         r_data_out <= w_data_nxt;
         r_pc_out   <= w_pc_out_nxt;
         r_pend     <= w_pend_nxt;
         r_redir_pc <= w_redir_pc_nxt;
      end
   end

   // next state and next register values
   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_mem_addr_nxt = r_mem_addr;
      w_mem_en_nxt   = r_mem_en;
      w_dor_nxt      = r_dor;
      w_data_nxt     = r_data_out;
      w_pc_out_nxt   = r_pc_out;
      w_pend_nxt     = r_pend;
      w_redir_pc_nxt = r_redir_pc;
`ifdef IFETCH_PREFETCH_EN
      w_pf_issue     = 1'b0;
      w_pf_take      = 1'b0;
      w_pf_handoff   = 1'b0;
`endif

      case (r_state)
         FETCH_REQ: begin
            w_mem_addr_nxt = w_fetch_addr;
            w_pc_nxt       = w_fetch_addr;
            w_pend_nxt     = 1'b0;
            w_mem_en_nxt   = 1'b1;
            w_state_nxt    = FETCH_WAIT;
         end
         FETCH_WAIT: begin
            if (mem_ack) begin
               w_mem_en_nxt = 1'b0;
               // a redirect seen before or with the ack makes this word stale
               if (r_pend || redirect_valid) begin
                  w_state_nxt = FETCH_REQ;
               end else begin
                  w_data_nxt   = mem_do;
                  w_pc_out_nxt = r_mem_addr;
                  w_dor_nxt    = 1'b1;
                  w_state_nxt  = OFFER;
               end
            end
         end
         OFFER: begin
            if (ack_from_next) begin
               w_dor_nxt   = 1'b0;
               w_pc_nxt    = r_pc + ADDR_W'(1);
               w_state_nxt = WAIT_RELEASE;
            end
         end
         WAIT_RELEASE: begin
            if (!ack_from_next) begin
`ifdef IFETCH_PREFETCH_EN
               if (w_buf_valid && !redirect_valid) begin
                  w_data_nxt   = w_buf_word;
                  w_pc_out_nxt = w_buf_addr;
                  w_dor_nxt    = 1'b1;
                  w_pf_take    = 1'b1;
                  w_state_nxt  = OFFER;
               end else if (w_pf_kept) begin
                  // prefetch lands exactly now: forward it without buffering
                  w_data_nxt   = mem_do;
                  w_pc_out_nxt = w_buf_addr;
                  w_dor_nxt    = 1'b1;
                  w_pf_take    = 1'b1;
                  w_state_nxt  = OFFER;
               end else if (w_pf_busy && !mem_ack) begin
                  // memory still busy with pc: let FETCH_WAIT collect it
                  w_pf_handoff = 1'b1;
                  w_state_nxt  = FETCH_WAIT;
               end else begin
                  w_state_nxt  = FETCH_REQ;
               end
`else
               w_state_nxt = FETCH_REQ;
`endif
            end
         end
         default: w_state_nxt = FETCH_REQ;
      endcase

`ifdef IFETCH_PREFETCH_EN
      // prefetch of the word after the one on offer
      if (w_pf_busy && mem_ack) begin
         w_mem_en_nxt = 1'b0;
      end
      if ((r_state == OFFER || (r_state == WAIT_RELEASE && ack_from_next)) &&
          !w_buf_valid && !w_pf_busy && !r_pend && !redirect_valid) begin
         w_pf_issue     = 1'b1;
         w_mem_en_nxt   = 1'b1;
         w_mem_addr_nxt = w_pf_addr;
      end
`endif

      // latest redirect wins; applied at the next FETCH_REQ
      if (redirect_valid) begin
         w_pend_nxt     = 1'b1;
         w_redir_pc_nxt = redirect_pc;
      end
   end

   assign mem_addr = r_mem_addr;
   assign mem_en   = r_mem_en;
   assign DOR      = r_dor;
   assign data_out = r_data_out;
   assign pc_out   = r_pc_out;

endmodule

// File: tb/tb_instruction_fetch.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch
// Directed self-checking bench for instruction_fetch. Memory word at address
// i is 0x20+i; memory ack latency is adjustable. Prefetch-specific sequence
// is selected by IFETCH_PREFETCH_EN.
// ----------------------------------------------------------------------------
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  mem_addr;
   logic        mem_en;
   logic [31:0] mem_do = '0;
   logic        mem_ack = 1'b0;
   logic        dor;
   logic [31:0] data_out;
   logic [9:0]  pc_out;
   logic        ack_from_next;
   logic        redirect_valid;
   logic [9:0]  redirect_pc;

   int n_checks = 0;
   int n_fail   = 0;
   int mem_lat  = 1;
   int mem_cnt  = 0;

   always #5 clk = ~clk;

   instruction_fetch #(
      .ADDR_W   (10),
      .RESET_PC (10'd0)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .mem_addr       (mem_addr),
      .mem_en         (mem_en),
      .mem_do         (mem_do),
      .mem_ack        (mem_ack),
      .DOR            (dor),
      .data_out       (data_out),
      .pc_out         (pc_out),
      .ack_from_next  (ack_from_next),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   // memory model: ack after mem_lat cycles of mem_en, one-cycle pulse
   always @(negedge clk) begin
      if (reset) begin
         mem_ack = 1'b0;
         mem_cnt = 0;
      end else if (mem_ack) begin
         mem_ack = 1'b0;
         mem_cnt = 0;
      end else if (mem_en) begin
         mem_cnt++;
         if (mem_cnt >= mem_lat) begin
            mem_ack = 1'b1;
            mem_do  = 32'h20 + 32'(mem_addr);
            mem_cnt = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic handshake();
      ack_from_next = 1'b1;
      tick();
      ack_from_next = 1'b0;
      tick();
   endtask

   task automatic wait_dor(input string tag, input logic [9:0] exp_pc, input logic [31:0] exp_data);
      int i = 0;
      while (!dor && i < 40) begin
         tick();
         i++;
      end
      check_eq({tag, "_dor"}, 32'(dor), 32'd1);
      check_eq({tag, "_pc_out"}, 32'(pc_out), 32'(exp_pc));
      check_eq({tag, "_data"}, data_out, exp_data);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset          = 1'b1;
      ack_from_next  = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      repeat (3) tick();
      check_eq("rst_dor",      32'(dor),      32'd0);
      check_eq("rst_mem_en",   32'(mem_en),   32'd0);
      check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
      check_eq("rst_data",     data_out,      32'd0);
      check_eq("rst_pc_out",   32'(pc_out),   32'd0);

      reset = 1'b0;
      tick();
      check_eq("req_mem_en", 32'(mem_en),   32'd1);
      check_eq("req_addr",   32'(mem_addr), 32'd0);
      tick();
      check_eq("first_dor",    32'(dor),    32'd1);
      check_eq("first_data",   data_out,    32'h20);
      check_eq("first_pc_out", 32'(pc_out), 32'd0);
      check_eq("first_mem_en", 32'(mem_en), 32'd0);

`ifndef IFETCH_PREFETCH_EN
      // decoder holds ack high for 5 cycles
      ack_from_next = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq("hold_dor",    32'(dor),    32'd0);
         check_eq("hold_mem_en", 32'(mem_en), 32'd0);
      end
      ack_from_next = 1'b0;
      tick();
      check_eq("rel_mem_en0", 32'(mem_en),   32'd0);
      tick();
      check_eq("rel_mem_en1", 32'(mem_en),   32'd1);
      check_eq("rel_addr",    32'(mem_addr), 32'd1);
      tick();
      check_eq("second_dor",    32'(dor),    32'd1);
      check_eq("second_data",   data_out,    32'h21);
      check_eq("second_pc_out", 32'(pc_out), 32'd1);

      // 3-cycle memory latency
      mem_lat = 3;
      handshake();
      tick();
      check_eq("lat_en0",   32'(mem_en),   32'd1);
      check_eq("lat_addr0", 32'(mem_addr), 32'd2);
      tick();
      check_eq("lat_en1",   32'(mem_en),   32'd1);
      check_eq("lat_addr1", 32'(mem_addr), 32'd2);
      check_eq("lat_data1", data_out,      32'h21);
      check_eq("lat_dor1",  32'(dor),      32'd0);
      tick();
      check_eq("lat_en2",   32'(mem_en),   32'd1);
      check_eq("lat_data2", data_out,      32'h21);
      tick();
      check_eq("lat_dor",    32'(dor),    32'd1);
      check_eq("lat_data",   data_out,    32'h22);
      check_eq("lat_pc_out", 32'(pc_out), 32'd2);
      check_eq("lat_en_off", 32'(mem_en), 32'd0);

      // redirect while fetching address 4
      handshake();
      wait_dor("w3", 10'd3, 32'h23);
      handshake();
      tick();
      check_eq("rd_addr", 32'(mem_addr), 32'd4);
      check_eq("rd_en",   32'(mem_en),   32'd1);
      redirect_valid = 1'b1;
      redirect_pc    = 10'h100;
      tick();
      redirect_valid = 1'b0;
      wait_dor("redir", 10'h100, 32'h120);
      mem_lat = 1;

      // redirect during OFFER does not retract the offered word
      redirect_valid = 1'b1;
      redirect_pc    = 10'h3FF;
      tick();
      redirect_valid = 1'b0;
      check_eq("offer_kept_dor", 32'(dor),    32'd1);
      check_eq("offer_kept_pc",  32'(pc_out), 32'h100);
      tick();
      check_eq("offer_kept_dor2", 32'(dor), 32'd1);
      handshake();
      wait_dor("wrap_src", 10'h3FF, 32'h41F);
      handshake();
      tick();
      check_eq("wrap_addr", 32'(mem_addr), 32'd0);
      check_eq("wrap_en",   32'(mem_en),   32'd1);
      wait_dor("wrap_dst", 10'd0, 32'h20);

      // redirect coinciding with mem_ack
      handshake();
      tick();
      check_eq("coinc_addr", 32'(mem_addr), 32'd1);
      redirect_valid = 1'b1;
      redirect_pc    = 10'h055;
      tick();
      redirect_valid = 1'b0;
      check_eq("coinc_dor", 32'(dor), 32'd0);
      wait_dor("coinc", 10'h055, 32'h75);
`else
      // buffered next word is offered one edge after ack release
      repeat (3) tick();
      check_eq("pf_hold_dor", 32'(dor),    32'd1);
      check_eq("pf_hold_pc",  32'(pc_out), 32'd0);
      ack_from_next = 1'b1;
      tick();
      check_eq("pf_dor_fall", 32'(dor), 32'd0);
      ack_from_next = 1'b0;
      tick();
      check_eq("pf_fast_dor",  32'(dor),    32'd1);
      check_eq("pf_fast_pc",   32'(pc_out), 32'd1);
      check_eq("pf_fast_data", data_out,    32'h21);

      // redirect while a prefetch is in flight
      mem_lat = 3;
      tick();
      check_eq("pf_inflight_en",   32'(mem_en),   32'd1);
      check_eq("pf_inflight_addr", 32'(mem_addr), 32'd2);
      redirect_valid = 1'b1;
      redirect_pc    = 10'h100;
      tick();
      redirect_valid = 1'b0;
      handshake();
      wait_dor("pf_redir", 10'h100, 32'h120);
      mem_lat = 1;
`endif

      // reset wins over a simultaneous redirect
      reset          = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 10'h077;
      tick();
      redirect_valid = 1'b0;
      tick();
      check_eq("rst2_dor",    32'(dor),    32'd0);
      check_eq("rst2_mem_en", 32'(mem_en), 32'd0);
      check_eq("rst2_pc_out", 32'(pc_out), 32'd0);
      reset = 1'b0;
      wait_dor("post_reset", 10'd0, 32'h20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
